// File: rtl/exe_hazard_ctrl_pkg.sv
// Shared widths, select encodings, FSM states and the hazard-entry record
// for the execute-stage hazard/forwarding controller.
package exe_hazard_ctrl_pkg;
  localparam int XLEN           = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int A_SEL_WIDTH    = 3;
  localparam int B_SEL_WIDTH    = 3;
  localparam int ALU_OP_WIDTH   = 4;

  localparam logic [A_SEL_WIDTH-1:0] A_SEL_RS1  = 3'd0;
  localparam logic [A_SEL_WIDTH-1:0] A_SEL_PC   = 3'd1;
  localparam logic [A_SEL_WIDTH-1:0] A_SEL_ZERO = 3'd2;
  localparam logic [A_SEL_WIDTH-1:0] A_SEL_ALU  = 3'd3;
  localparam logic [A_SEL_WIDTH-1:0] A_SEL_MEM  = 3'd4;

  localparam logic [B_SEL_WIDTH-1:0] B_SEL_RS2  = 3'd0;
  localparam logic [B_SEL_WIDTH-1:0] B_SEL_IMM  = 3'd1;
  localparam logic [B_SEL_WIDTH-1:0] B_SEL_FOUR = 3'd2;
  localparam logic [B_SEL_WIDTH-1:0] B_SEL_ZERO = 3'd3;
  localparam logic [B_SEL_WIDTH-1:0] B_SEL_ALU  = 3'd4;
  localparam logic [B_SEL_WIDTH-1:0] B_SEL_MEM  = 3'd5;

  typedef enum logic {RUN, LD_STALL} state_e;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      we;
    logic                      ld;
  } haz_ent_t;

  localparam haz_ent_t HAZ_BUBBLE = '{rd: '0, we: 1'b0, ld: 1'b0};
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_BUBBLE = '0;
endpackage

// File: rtl/exe_hazard_ctrl_fwd_sel.sv
// Per-operand forwarding select: picks EXE/MEM bypass or the decoder's
// nominal source, and flags a load in EXE that this operand depends on.
module exe_hazard_ctrl_fwd_sel
  import exe_hazard_ctrl_pkg::*;
#(
  parameter int                 SEL_W   = 3,
  parameter logic [SEL_W-1:0]   SEL_REG = '0,
  parameter logic [SEL_W-1:0]   SEL_ALU = '0,
  parameter logic [SEL_W-1:0]   SEL_MEM = '0
) (
  input  logic [REG_ADDR_WIDTH-1:0] src,
  input  logic [SEL_W-1:0]          nom_sel,
  input  haz_ent_t                  exe_ent,
  input  haz_ent_t                  mem_ent,
  output logic [SEL_W-1:0]          sel,
  output logic                      ld_haz
);
  logic reg_src, exe_hit, mem_hit;

  always_comb begin
    // x0 and non-register operands never take a bypass
    reg_src = (src != '0) && (nom_sel == SEL_REG);
    exe_hit = reg_src && exe_ent.we && (exe_ent.rd == src);
    mem_hit = reg_src && mem_ent.we && (mem_ent.rd == src);
    ld_haz  = exe_hit && exe_ent.ld;
    sel     = nom_sel;
    if (exe_hit && !exe_ent.ld) sel = SEL_ALU;
    else if (mem_hit)           sel = SEL_MEM;
  end
endmodule

// File: rtl/exe_hazard_ctrl.sv
// ID/EXE control register with forwarding selects, load-use bubbles,
// branch squash and memory-hold freeze.
module exe_hazard_ctrl
  import exe_hazard_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_id,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_id,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_id,
  input  logic [A_SEL_WIDTH-1:0]    a_src_id,
  input  logic [B_SEL_WIDTH-1:0]    b_src_id,
  input  logic [ALU_OP_WIDTH-1:0]   alu_op_id,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_id,
  input  logic                      reg_we_id,
  input  logic                      is_load_id,
  input  logic                      branch_taken_exe,
  input  logic                      mem_hold,
  output logic [A_SEL_WIDTH-1:0]    a_sel,
  output logic [B_SEL_WIDTH-1:0]    b_sel,
  output logic [ALU_OP_WIDTH-1:0]   alu_op,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_exe,
  output logic                      reg_we_exe,
  output logic                      stall_if_id,
  output logic                      flush_if_id
);
  state_e                    state_q, state_d;
  haz_ent_t                  exe_q, exe_d, mem_q, mem_d;
  logic [A_SEL_WIDTH-1:0]    a_sel_q, a_sel_d, a_fwd;
  logic [B_SEL_WIDTH-1:0]    b_sel_q, b_sel_d, b_fwd;
  logic [ALU_OP_WIDTH-1:0]   alu_op_q, alu_op_d;
  logic                      a_ld_haz, b_ld_haz, load_use;

  exe_hazard_ctrl_fwd_sel #(
    .SEL_W(A_SEL_WIDTH), .SEL_REG(A_SEL_RS1), .SEL_ALU(A_SEL_ALU), .SEL_MEM(A_SEL_MEM)
  ) u_fwd_a (
    .src(rs1_addr_id), .nom_sel(a_src_id), .exe_ent(exe_q), .mem_ent(mem_q),
    .sel(a_fwd), .ld_haz(a_ld_haz)
  );

  exe_hazard_ctrl_fwd_sel #(
    .SEL_W(B_SEL_WIDTH), .SEL_REG(B_SEL_RS2), .SEL_ALU(B_SEL_ALU), .SEL_MEM(B_SEL_MEM)
  ) u_fwd_b (
    .src(rs2_addr_id), .nom_sel(b_src_id), .exe_ent(exe_q), .mem_ent(mem_q),
    .sel(b_fwd), .ld_haz(b_ld_haz)
  );

  assign load_use = valid_id && (a_ld_haz || b_ld_haz);

  always_comb begin
    state_d     = RUN;
    a_sel_d     = A_SEL_ZERO;
    b_sel_d     = B_SEL_ZERO;
    alu_op_d    = ALU_OP_BUBBLE;
    exe_d       = HAZ_BUBBLE;
    mem_d       = exe_q;
    stall_if_id = 1'b0;
    flush_if_id = 1'b0;
    // Hold wins over everything; a pending branch is seen again once it drops
    if (mem_hold) begin
      state_d     = state_q;
      a_sel_d     = a_sel_q;
      b_sel_d     = b_sel_q;
      alu_op_d    = alu_op_q;
      exe_d       = exe_q;
      mem_d       = mem_q;
      stall_if_id = 1'b1;
    end else if (branch_taken_exe) begin
      flush_if_id = 1'b1;
    end else if (load_use) begin
      // The load reaches MEM next cycle, so the retry resolves to a MEM bypass
      state_d     = LD_STALL;
      stall_if_id = 1'b1;
    end else if (valid_id) begin
      a_sel_d  = a_fwd;
      b_sel_d  = b_fwd;
      alu_op_d = alu_op_id;
      exe_d    = '{rd: rd_addr_id, we: reg_we_id, ld: is_load_id};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      a_sel_q  <= A_SEL_ZERO;
      b_sel_q  <= B_SEL_ZERO;
      alu_op_q <= ALU_OP_BUBBLE;
      exe_q    <= HAZ_BUBBLE;
      mem_q    <= HAZ_BUBBLE;
    end else begin
      state_q  <= state_d;
      a_sel_q  <= a_sel_d;
      b_sel_q  <= b_sel_d;
      alu_op_q <= alu_op_d;
      exe_q    <= exe_d;
      mem_q    <= mem_d;
    end
  end

  assign a_sel       = a_sel_q;
  assign b_sel       = b_sel_q;
  assign alu_op      = alu_op_q;
  assign rd_addr_exe = exe_q.rd;
  assign reg_we_exe  = exe_q.we;
endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Directed bench for exe_hazard_ctrl: forwarding, load-use, branch, hold, reset.
module tb_exe_hazard_ctrl;
  import exe_hazard_ctrl_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      valid_id;
  logic [REG_ADDR_WIDTH-1:0] rs1_addr_id, rs2_addr_id, rd_addr_id;
  logic [A_SEL_WIDTH-1:0]    a_src_id;
  logic [B_SEL_WIDTH-1:0]    b_src_id;
  logic [ALU_OP_WIDTH-1:0]   alu_op_id;
  logic                      reg_we_id, is_load_id, branch_taken_exe, mem_hold;
  logic [A_SEL_WIDTH-1:0]    a_sel;
  logic [B_SEL_WIDTH-1:0]    b_sel;
  logic [ALU_OP_WIDTH-1:0]   alu_op;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_exe;
  logic                      reg_we_exe, stall_if_id, flush_if_id;

  int tests = 0;
  int fails = 0;

  exe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .valid_id(valid_id),
    .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id),
    .a_src_id(a_src_id), .b_src_id(b_src_id), .alu_op_id(alu_op_id),
    .rd_addr_id(rd_addr_id), .reg_we_id(reg_we_id), .is_load_id(is_load_id),
    .branch_taken_exe(branch_taken_exe), .mem_hold(mem_hold),
    .a_sel(a_sel), .b_sel(b_sel), .alu_op(alu_op), .rd_addr_exe(rd_addr_exe),
    .reg_we_exe(reg_we_exe), .stall_if_id(stall_if_id), .flush_if_id(flush_if_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int rs1, input int rs2,
                       input logic [A_SEL_WIDTH-1:0] as, input logic [B_SEL_WIDTH-1:0] bs,
                       input int op, input int rd, input logic we, input logic ld);
    valid_id    = v;
    rs1_addr_id = REG_ADDR_WIDTH'(rs1);
    rs2_addr_id = REG_ADDR_WIDTH'(rs2);
    a_src_id    = as;
    b_src_id    = bs;
    alu_op_id   = ALU_OP_WIDTH'(op);
    rd_addr_id  = REG_ADDR_WIDTH'(rd);
    reg_we_id   = we;
    is_load_id  = ld;
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 0, 0, A_SEL_ZERO, B_SEL_ZERO, 0, 0, 1'b0, 1'b0);
  endtask

  // Registered outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_a"},  32'(a_sel),      32'(A_SEL_ZERO));
    chk({tag, "_b"},  32'(b_sel),      32'(B_SEL_ZERO));
    chk({tag, "_op"}, 32'(alu_op),     32'd0);
    chk({tag, "_rd"}, 32'(rd_addr_exe), 32'd0);
    chk({tag, "_we"}, 32'(reg_we_exe), 32'd0);
  endtask

  initial begin
    rst = 1'b1; branch_taken_exe = 1'b0; mem_hold = 1'b0;
    nop();
    #2;
    chk_bubble("rst");
    chk("rst_stall", 32'(stall_if_id), 32'd0);
    chk("rst_flush", 32'(flush_if_id), 32'd0);
    #10 rst = 1'b0;
    tick();

    // 1: add x5,x1,x2 ; sub x6,x5,x7
    drive(1'b1, 1, 2, A_SEL_RS1, B_SEL_RS2, 1, 5, 1'b1, 1'b0);
    tick();
    chk("t1_add_a",  32'(a_sel), 32'(A_SEL_RS1));
    chk("t1_add_rd", 32'(rd_addr_exe), 32'd5);
    chk("t1_add_we", 32'(reg_we_exe), 32'd1);
    drive(1'b1, 5, 7, A_SEL_RS1, B_SEL_RS2, 2, 6, 1'b1, 1'b0);
    chk("t1_stall", 32'(stall_if_id), 32'd0);
    tick();
    chk("t1_sub_a",  32'(a_sel), 32'(A_SEL_ALU));
    chk("t1_sub_b",  32'(b_sel), 32'(B_SEL_RS2));
    chk("t1_sub_op", 32'(alu_op), 32'd2);

    // 2: add x5 ; nop ; or x8,x5,x5
    drive(1'b1, 1, 2, A_SEL_RS1, B_SEL_RS2, 1, 5, 1'b1, 1'b0);
    tick();
    nop();
    tick();
    chk("t2_nop_we", 32'(reg_we_exe), 32'd0);
    drive(1'b1, 5, 5, A_SEL_RS1, B_SEL_RS2, 3, 8, 1'b1, 1'b0);
    tick();
    chk("t2_or_a", 32'(a_sel), 32'(A_SEL_MEM));
    chk("t2_or_b", 32'(b_sel), 32'(B_SEL_MEM));

    // 3: lw x5 ; add x6,x5,x1
    drive(1'b1, 1, 0, A_SEL_RS1, B_SEL_IMM, 0, 5, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5, 1, A_SEL_RS1, B_SEL_RS2, 1, 6, 1'b1, 1'b0);
    chk("t3_stall_on", 32'(stall_if_id), 32'd1);
    tick();
    chk_bubble("t3_bub");
    chk("t3_stall_off", 32'(stall_if_id), 32'd0);
    tick();
    chk("t3_a",  32'(a_sel), 32'(A_SEL_MEM));
    chk("t3_b",  32'(b_sel), 32'(B_SEL_RS2));
    chk("t3_rd", 32'(rd_addr_exe), 32'd6);
    chk("t3_we", 32'(reg_we_exe), 32'd1);

    // 4: write x0 then read x0; auipc after write to x10 with rs1 field 10
    drive(1'b1, 1, 0, A_SEL_RS1, B_SEL_IMM, 1, 0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 0, 0, A_SEL_RS1, B_SEL_RS2, 1, 9, 1'b1, 1'b0);
    tick();
    chk("t4_x0_a", 32'(a_sel), 32'(A_SEL_RS1));
    chk("t4_x0_b", 32'(b_sel), 32'(B_SEL_RS2));
    drive(1'b1, 1, 2, A_SEL_RS1, B_SEL_RS2, 1, 10, 1'b1, 1'b0);
    tick();
    drive(1'b1, 10, 10, A_SEL_PC, B_SEL_IMM, 1, 11, 1'b1, 1'b0);
    tick();
    chk("t4_auipc_a", 32'(a_sel), 32'(A_SEL_PC));
    chk("t4_auipc_b", 32'(b_sel), 32'(B_SEL_IMM));

    // 5: branch taken in the same cycle as a load-use hazard
    drive(1'b1, 1, 0, A_SEL_RS1, B_SEL_IMM, 0, 5, 1'b1, 1'b1);
    tick();
    branch_taken_exe = 1'b1;
    drive(1'b1, 5, 1, A_SEL_RS1, B_SEL_RS2, 1, 6, 1'b1, 1'b0);
    chk("t5_flush", 32'(flush_if_id), 32'd1);
    chk("t5_stall", 32'(stall_if_id), 32'd0);
    tick();
    branch_taken_exe = 1'b0;
    chk_bubble("t5_bub");
    drive(1'b1, 5, 0, A_SEL_RS1, B_SEL_RS2, 4, 12, 1'b1, 1'b0);
    chk("t5_run_stall", 32'(stall_if_id), 32'd0);
    chk("t5_run_flush", 32'(flush_if_id), 32'd0);
    tick();
    chk("t5_run_a",  32'(a_sel), 32'(A_SEL_MEM));
    chk("t5_run_rd", 32'(rd_addr_exe), 32'd12);

    // 6: hold for 3 cycles in the middle of a load stall
    drive(1'b1, 1, 0, A_SEL_RS1, B_SEL_IMM, 0, 5, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5, 1, A_SEL_RS1, B_SEL_RS2, 1, 6, 1'b1, 1'b0);
    chk("t6_stall_on", 32'(stall_if_id), 32'd1);
    tick();
    chk_bubble("t6_bub");
    mem_hold = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("t6_hold_stall", 32'(stall_if_id), 32'd1);
      chk("t6_hold_flush", 32'(flush_if_id), 32'd0);
      tick();
      chk_bubble("t6_hold");
    end
    mem_hold = 1'b0;
    #1;
    chk("t6_resume_stall", 32'(stall_if_id), 32'd0);
    tick();
    chk("t6_a",  32'(a_sel), 32'(A_SEL_MEM));
    chk("t6_rd", 32'(rd_addr_exe), 32'd6);
    chk("t6_we", 32'(reg_we_exe), 32'd1);

    // Async reset with no clock edge
    #2 rst = 1'b1;
    #1;
    chk_bubble("t6_rst");
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
